// File: rtl/smb_pkg.sv
// smb_pkg: shared frame states and switch geometry for the serial multi-bus frame controller
package smb_pkg;
  typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, DONE} frame_state_t;
  localparam int NUM_PORTS = 4;
  localparam int LANE_BITS = 4;
endpackage

// File: rtl/smb_shift_field.sv
// smb_shift_field: MSB-first serial field capture with bit counter; o_full flags the shift that completes the field
// Ports: clk, rst (async active-low), i_clr (restart field), i_en (shift i_bit in), o_val (captured field), o_full (this shift is the last)
module smb_shift_field #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_val,
  output logic         o_full
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_val;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_val <= {r_val[W-2:0], i_bit};
      r_cnt <= r_cnt + 1'b1;
    end
  assign o_val  = r_val;
  assign o_full = i_en && (r_cnt == CW'(W - 1));
endmodule

// File: rtl/smb_frame_ctrl.sv
// smb_frame_ctrl: parses start/port/length/payload serial frames and steers payload bits into the multi-bus switch
// Ports: clk, rst (async active-low), serin (serial line, idles high); ser_out/PB/LB/word_end drive the switch during DATA; busy outside IDLE; done one-cycle end-of-frame pulse
module smb_frame_ctrl
  import smb_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serin,
  output logic                 ser_out,
  output logic [NUM_PORTS-1:0] PB,
  output logic [1:0]           LB,
  output logic                 word_end,
  output logic                 busy,
  output logic                 done
);
  frame_state_t     r_state, w_next;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [1:0]       w_port;
  logic [LEN_W-1:0] w_len;
  logic             w_port_full, w_len_full, w_start, w_len_zero, w_last_bit, w_in_data;
  assign w_start    = (r_state == IDLE) && !serin;
  assign w_in_data  = r_state == DATA;
  assign w_last_bit = r_bit_cnt == w_len - LEN_W'(1);
  // the length register has not yet absorbed the final bit on the completing edge
  assign w_len_zero = {w_len[LEN_W-2:0], serin} == '0;
  smb_shift_field #(.W(2)) u_port (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (r_state == PORT),
    .i_bit  (serin),
    .o_val  (w_port),
    .o_full (w_port_full)
  );
  smb_shift_field #(.W(LEN_W)) u_len (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (r_state == LEN),
    .i_bit  (serin),
    .o_val  (w_len),
    .o_full (w_len_full)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_bit_cnt <= w_start ? '0 : w_in_data ? r_bit_cnt + 1'b1 : r_bit_cnt;
    end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = serin ? IDLE : PORT;
      PORT:    w_next = w_port_full ? LEN : PORT;
      LEN:     w_next = w_len_full ? (w_len_zero ? DONE : DATA) : LEN;
      DATA:    w_next = w_last_bit ? DONE : DATA;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    PB       = w_in_data ? NUM_PORTS'(1) << w_port : '0;
    LB       = w_in_data ? r_bit_cnt[1:0] : '0;
    ser_out  = w_in_data & serin;
    word_end = w_in_data && ((r_bit_cnt[1:0] == 2'(LANE_BITS - 1)) || w_last_bit);
    busy     = r_state != IDLE;
    done     = r_state == DONE;
  end
endmodule

// File: tb/tb_smb_frame_ctrl.sv
// tb_smb_frame_ctrl: table-driven frames with a per-cycle expected-output scoreboard plus reset and idle corner sequences
module tb_smb_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serin = 1'b1;
  logic       ser_out, word_end, busy, done;
  logic [3:0] PB;
  logic [1:0] LB;
  always #5 clk = ~clk;
  smb_frame_ctrl #(.LEN_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .serin    (serin),
    .ser_out  (ser_out),
    .PB       (PB),
    .LB       (LB),
    .word_end (word_end),
    .busy     (busy),
    .done     (done)
  );
  typedef struct {
    logic [3:0] pb;
    logic [1:0] lb;
    logic       so, we, busy, done, last;
    int         we_total;
  } exp_t;
  typedef struct {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [15:0] pay;
    logic [3:0]  pb;
    int          we_n;
    logic        done_s;
    int          gap;
  } frame_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic exp_t idle_exp();
    exp_t e;
    e.pb = '0;
    e.lb = '0;
    e.so = 1'b0;
    e.we = 1'b0;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.last = 1'b0;
    e.we_total = 0;
    return e;
  endfunction
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) we_cnt = 0;
    if (q.size() > 0) begin
      e = q.pop_front();
      we_cnt += int'(word_end);
      chk("outs{PB,LB,ser_out,word_end,busy,done}", 32'({PB, LB, ser_out, word_end, busy, done}),
          32'({e.pb, e.lb, e.so, e.we, e.busy, e.done}));
      if (e.last) begin
        chk("word_end_count", we_cnt, e.we_total);
        we_cnt = 0;
      end
    end
  end
  task automatic cyc(input logic s, input exp_t e, input logic r);
    @(negedge clk);
    serin = s;
    rst = r;
    q.push_back(e);
  endtask
  task automatic send_frame(input frame_t f, input int cut);
    exp_t e;
    e = idle_exp();
    cyc(1'b0, e, 1'b1);
    e.busy = 1'b1;
    cyc(f.port[1], e, 1'b1);
    cyc(f.port[0], e, 1'b1);
    for (int i = 3; i >= 0; i--) cyc(f.len[i], e, 1'b1);
    for (int i = 0; i < int'(f.len); i++) begin
      if (i == cut) begin
        @(negedge clk);
        serin = f.pay[i];
        #1 rst = 1'b0;
        q.push_back(idle_exp());
        return;
      end
      e = idle_exp();
      e.busy = 1'b1;
      e.pb = f.pb;
      e.lb = 2'(i);
      e.so = f.pay[i];
      e.we = (i % 4 == 3) || (i == int'(f.len) - 1);
      cyc(f.pay[i], e, 1'b1);
    end
    e = idle_exp();
    e.busy = 1'b1;
    e.done = 1'b1;
    e.last = 1'b1;
    e.we_total = f.we_n;
    cyc(f.done_s, e, 1'b1);
    for (int i = 0; i < f.gap; i++) cyc(1'b1, idle_exp(), 1'b1);
  endtask
  initial begin
    frame_t t[6];
    frame_t cut_f;
    t[0] = '{2'd2, 4'd6,  16'h002D, 4'b0100, 2, 1'b1, 2};
    t[1] = '{2'd3, 4'd0,  16'h0000, 4'b0000, 0, 1'b1, 1};
    t[2] = '{2'd0, 4'd15, 16'h5A3C, 4'b0001, 4, 1'b1, 1};
    t[3] = '{2'd1, 4'd4,  16'h000B, 4'b0010, 1, 1'b0, 0};
    t[4] = '{2'd3, 4'd5,  16'h0013, 4'b1000, 2, 1'b1, 1};
    t[5] = '{2'd1, 4'd1,  16'h0001, 4'b0010, 1, 1'b1, 0};
    cut_f = '{2'd1, 4'd6, 16'h003F, 4'b0010, 2, 1'b1, 0};
    serin = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_PB", 32'(PB), 32'd0);
    chk("reset_LB", 32'(LB), 32'd0);
    chk("reset_ser_out", 32'(ser_out), 32'd0);
    chk("reset_word_end", 32'(word_end), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) send_frame(t[i], -1);
    send_frame(cut_f, 2);
    repeat (2) cyc(1'b1, idle_exp(), 1'b0);
    send_frame(t[0], -1);
    repeat (20) cyc(1'b1, idle_exp(), 1'b1);
    @(negedge clk);
    #5;
    chk("scoreboard_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
